// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: latches an int_req edge, waits for a safe pipeline point,
// pushes return PC and flags, fetches the ISR vector, loads PC and tracks ISR residency.
`timescale 1ns/1ps
module interrupt_sequencer #(
   parameter int             W        = 16,
   parameter int             FLAGS_W  = 4,
   parameter logic [W-1:0]   VEC_ADDR = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               int_req,
   input  logic               branch_signal,
   input  logic               detection_signal,
   input  logic               call_in_decode,
   input  logic [W-1:0]       pc_next,
   input  logic [FLAGS_W-1:0] flags_in,
   input  logic               reti_done,
   input  logic               push_ready,
   input  logic               vec_rd_ready,
   input  logic [W-1:0]       vec_rd_data,
   output logic               interrupt,
   output logic               stall,
   output logic               push_valid,
   output logic [W-1:0]       push_data,
   output logic               vec_rd_valid,
   output logic [W-1:0]       vec_addr,
   output logic               pc_load,
   output logic [W-1:0]       pc_load_value,
   output logic               in_isr
);

   typedef enum logic [2:0] {
      IDLE,
      PENDING,
      PUSH_PC,
      PUSH_FLAGS,
      VEC_RD,
      JUMP,
      ISR
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 int_req_q;
   logic                 pending;
   logic                 first_cycle;
   logic [W-1:0]         saved_pc;
   logic [FLAGS_W-1:0]   saved_flags;
   logic [W-1:0]         vector;
   logic                 req_edge;
   logic                 safe;
   logic                 enter;

   assign req_edge = int_req & ~int_req_q;
   assign safe     = ~branch_signal & ~detection_signal & ~call_in_decode;
   assign enter    = (state == PENDING) & safe;
   assign vec_addr = VEC_ADDR;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         int_req_q   <= 1'b0;
         pending     <= 1'b0;
         first_cycle <= 1'b0;
         saved_pc    <= '0;
         saved_flags <= '0;
         vector      <= '0;
         in_isr      <= 1'b0;
      end else begin
         state     <= state_next;
         int_req_q <= int_req;
         // A new edge wins over the clear so an edge arriving on the entry cycle is kept.
         if (req_edge)
            pending <= 1'b1;
         else if (enter)
            pending <= 1'b0;
         // Marks the first PUSH_PC cycle so interrupt pulses once even under backpressure.
         first_cycle <= enter;
         if (enter) begin
            saved_pc    <= pc_next;
            saved_flags <= flags_in;
         end
         if ((state == VEC_RD) && vec_rd_ready)
            vector <= vec_rd_data;
         if (state == JUMP)
            in_isr <= 1'b1;
         else if ((state == ISR) && reti_done)
            in_isr <= 1'b0;
      end
   end

   always_comb begin
      state_next    = state;
      interrupt     = 1'b0;
      stall         = 1'b0;
      push_valid    = 1'b0;
      push_data     = '0;
      vec_rd_valid  = 1'b0;
      pc_load       = 1'b0;
      pc_load_value = '0;
      case (state)
         IDLE: begin
            if (req_edge | pending)
               state_next = PENDING;
         end
         PENDING: begin
            if (safe)
               state_next = PUSH_PC;
         end
         PUSH_PC: begin
            stall      = 1'b1;
            push_valid = 1'b1;
            push_data  = saved_pc;
            interrupt  = first_cycle;
            if (push_ready)
               state_next = PUSH_FLAGS;
         end
         PUSH_FLAGS: begin
            stall      = 1'b1;
            push_valid = 1'b1;
            push_data  = {{(W-FLAGS_W){1'b0}}, saved_flags};
            if (push_ready)
               state_next = VEC_RD;
         end
         VEC_RD: begin
            stall        = 1'b1;
            vec_rd_valid = 1'b1;
            if (vec_rd_ready)
               state_next = JUMP;
         end
         JUMP: begin
            stall         = 1'b1;
            pc_load       = 1'b1;
            pc_load_value = vector;
            state_next    = ISR;
         end
         ISR: begin
            if (reti_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: a step-sequence reference model checked every
// cycle on the falling edge, plus literal expectations taken from hand-worked timelines.
`timescale 1ns/1ps
module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        int_req, branch_signal, detection_signal, call_in_decode;
   logic [15:0] pc_next;
   logic [3:0]  flags_in;
   logic        reti_done, push_ready, vec_rd_ready;
   logic [15:0] vec_rd_data;
   logic        interrupt, stall, push_valid, vec_rd_valid, pc_load, in_isr;
   logic [15:0] push_data, vec_addr, pc_load_value;

   int total = 0;
   int bad   = 0;
   int irq_cnt = 0;
   int mark;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   interrupt_sequencer #(.W(16), .FLAGS_W(4), .VEC_ADDR(16'h0000)) dut (
      .clk(clk), .rst(rst), .int_req(int_req), .branch_signal(branch_signal),
      .detection_signal(detection_signal), .call_in_decode(call_in_decode),
      .pc_next(pc_next), .flags_in(flags_in), .reti_done(reti_done),
      .push_ready(push_ready), .vec_rd_ready(vec_rd_ready), .vec_rd_data(vec_rd_data),
      .interrupt(interrupt), .stall(stall), .push_valid(push_valid), .push_data(push_data),
      .vec_rd_valid(vec_rd_valid), .vec_addr(vec_addr), .pc_load(pc_load),
      .pc_load_value(pc_load_value), .in_isr(in_isr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entry is a fixed list of steps 0..6, each advancing when its
   // completion condition holds; step 6 (in the ISR) wraps back to step 0.
   int          m_ph, m_age;
   logic        m_pend, m_prev;
   logic [15:0] m_pc, m_vec;
   logic [3:0]  m_fl;
   wire m_edge = int_req & ~m_prev;
   wire m_safe = !(branch_signal || detection_signal || call_in_decode);

   function automatic bit step_done(input int ph);
      case (ph)
         0: return m_edge | m_pend;
         1: return m_safe;
         2, 3: return push_ready;
         4: return vec_rd_ready;
         5: return 1'b1;
         default: return reti_done;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ph <= 0; m_age <= 0; m_pend <= 1'b0; m_prev <= 1'b0;
         m_pc <= '0; m_vec <= '0; m_fl <= '0;
      end else begin
         m_prev <= int_req;
         m_pend <= m_edge ? 1'b1 : ((m_ph == 1 && m_safe) ? 1'b0 : m_pend);
         if (m_ph == 1 && m_safe) begin
            m_pc <= pc_next;
            m_fl <= flags_in;
         end
         if (m_ph == 4 && vec_rd_ready) m_vec <= vec_rd_data;
         if (step_done(m_ph)) begin
            m_ph  <= (m_ph + 1) % 7;
            m_age <= 0;
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   wire        e_int   = (m_ph == 2) && (m_age == 0);
   wire        e_stall = (m_ph >= 2) && (m_ph <= 5);
   wire        e_pv    = (m_ph == 2) || (m_ph == 3);
   wire [15:0] e_pd    = (m_ph == 2) ? m_pc : ((m_ph == 3) ? {12'h000, m_fl} : 16'h0000);
   wire        e_vrv   = (m_ph == 4);
   wire        e_pcl   = (m_ph == 5);
   wire [15:0] e_pclv  = (m_ph == 5) ? m_vec : 16'h0000;
   wire        e_isr   = (m_ph == 6);

   always @(negedge clk) begin
      if (interrupt === 1'b1) irq_cnt++;
      if (cmp_en) begin
         chk("m_interrupt", {31'b0, interrupt}, {31'b0, e_int});
         chk("m_stall", {31'b0, stall}, {31'b0, e_stall});
         chk("m_push_valid", {31'b0, push_valid}, {31'b0, e_pv});
         chk("m_push_data", {16'b0, push_data}, {16'b0, e_pd});
         chk("m_vec_rd_valid", {31'b0, vec_rd_valid}, {31'b0, e_vrv});
         chk("m_vec_addr", {16'b0, vec_addr}, 32'h0);
         chk("m_pc_load", {31'b0, pc_load}, {31'b0, e_pcl});
         chk("m_pc_load_value", {16'b0, pc_load_value}, {16'b0, e_pclv});
         chk("m_in_isr", {31'b0, in_isr}, {31'b0, e_isr});
      end
   end

   task automatic wait_isr(input string name, input int maxc);
      int n = 0;
      while (in_isr !== 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'b0, in_isr}, 32'h1);
   endtask

   task automatic reti_pulse();
      @(negedge clk) reti_done = 1'b1;
      @(negedge clk) reti_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; int_req = 1'b0; branch_signal = 1'b0; detection_signal = 1'b0;
      call_in_decode = 1'b0; pc_next = 16'h0042; flags_in = 4'b1010; reti_done = 1'b0;
      push_ready = 1'b1; vec_rd_ready = 1'b1; vec_rd_data = 16'h0100;
      repeat (3) @(negedge clk);
      chk("rst_interrupt", {31'b0, interrupt}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_push_data", {16'b0, push_data}, 32'h0);
      chk("rst_in_isr", {31'b0, in_isr}, 32'h0);
      cmp_en = 1'b1;
      rst = 1'b1;

      // Basic entry; int_req stays high throughout to prove a held request is one event.
      @(negedge clk) int_req = 1'b1;
      @(negedge clk);
      chk("basic_pending_nopush", {31'b0, push_valid}, 32'h0);
      @(negedge clk);
      chk("basic_interrupt", {31'b0, interrupt}, 32'h1);
      chk("basic_push_pc", {16'b0, push_data}, 32'h0042);
      chk("basic_stall1", {31'b0, stall}, 32'h1);
      @(negedge clk);
      chk("basic_push_flags", {16'b0, push_data}, 32'h000A);
      chk("basic_int_once", {31'b0, interrupt}, 32'h0);
      @(negedge clk);
      chk("basic_vec_rd", {31'b0, vec_rd_valid}, 32'h1);
      @(negedge clk);
      chk("basic_pc_load", {31'b0, pc_load}, 32'h1);
      chk("basic_pc_value", {16'b0, pc_load_value}, 32'h0100);
      chk("basic_stall4", {31'b0, stall}, 32'h1);
      @(negedge clk);
      chk("basic_in_isr", {31'b0, in_isr}, 32'h1);
      chk("basic_stall_off", {31'b0, stall}, 32'h0);
      repeat (3) @(negedge clk);
      reti_pulse();
      chk("basic_isr_exit", {31'b0, in_isr}, 32'h0);
      mark = irq_cnt;
      repeat (10) @(negedge clk);
      chk("held_req_single", irq_cnt - mark, 32'h0);
      int_req = 1'b0;

      // Stray RETI while idle.
      reti_pulse();
      repeat (3) @(negedge clk);
      chk("stray_reti_isr", {31'b0, in_isr}, 32'h0);
      chk("stray_reti_stall", {31'b0, stall}, 32'h0);

      // Deferral by hazard stall then CALL in Decode.
      detection_signal = 1'b1; int_req = 1'b1; pc_next = 16'h0111; flags_in = 4'b0101;
      repeat (3) @(negedge clk);
      chk("defer_det", {31'b0, push_valid}, 32'h0);
      detection_signal = 1'b0; call_in_decode = 1'b1;
      @(negedge clk);
      chk("defer_call1", {31'b0, push_valid}, 32'h0);
      @(negedge clk);
      chk("defer_call2", {31'b0, push_valid}, 32'h0);
      call_in_decode = 1'b0; pc_next = 16'h0222; flags_in = 4'b0011; int_req = 1'b0;
      @(negedge clk);
      chk("defer_interrupt", {31'b0, interrupt}, 32'h1);
      chk("defer_pc", {16'b0, push_data}, 32'h0222);
      pc_next = 16'h0333;
      @(negedge clk);
      chk("defer_flags", {16'b0, push_data}, 32'h0003);
      wait_isr("defer_isr", 10);
      reti_pulse();

      // Stack-port backpressure for four cycles in PUSH_PC.
      push_ready = 1'b0; pc_next = 16'h0444; flags_in = 4'b1111; mark = irq_cnt;
      int_req = 1'b1;
      @(negedge clk) int_req = 1'b0;
      @(negedge clk);
      chk("bp_interrupt", {31'b0, interrupt}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         chk("bp_push_valid", {31'b0, push_valid}, 32'h1);
         chk("bp_push_data", {16'b0, push_data}, 32'h0444);
         if (i < 3) @(negedge clk);
      end
      push_ready = 1'b1;
      @(negedge clk);
      chk("bp_flags", {16'b0, push_data}, 32'h000F);
      wait_isr("bp_isr", 10);
      chk("bp_irq_once", irq_cnt - mark, 32'h1);
      reti_pulse();

      // No nesting: three edges inside the ISR collapse into one later entry.
      @(negedge clk) int_req = 1'b1;
      @(negedge clk) int_req = 1'b0;
      wait_isr("nest_isr1", 10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) int_req = 1'b1;
         @(negedge clk) int_req = 1'b0;
      end
      mark = irq_cnt;
      repeat (4) @(negedge clk);
      chk("nest_still_isr", {31'b0, in_isr}, 32'h1);
      chk("nest_no_irq", irq_cnt - mark, 32'h0);
      reti_pulse();
      chk("nest_exit", {31'b0, in_isr}, 32'h0);
      wait_isr("nest_isr2", 20);
      chk("nest_one_entry", irq_cnt - mark, 32'h1);
      reti_pulse();
      repeat (12) @(negedge clk);
      chk("nest_no_third", irq_cnt - mark, 32'h1);

      // Reset during VEC_RD with a further edge pending.
      vec_rd_ready = 1'b0; int_req = 1'b1;
      for (int n = 0; n < 10 && vec_rd_valid !== 1'b1; n++) @(negedge clk);
      chk("rstmid_in_vec_rd", {31'b0, vec_rd_valid}, 32'h1);
      int_req = 1'b0;
      @(negedge clk) int_req = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rstmid_vec_rd", {31'b0, vec_rd_valid}, 32'h0);
      chk("rstmid_stall", {31'b0, stall}, 32'h0);
      chk("rstmid_push", {31'b0, push_valid}, 32'h0);
      chk("rstmid_pc_load", {31'b0, pc_load}, 32'h0);
      int_req = 1'b0; vec_rd_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mark = irq_cnt;
      repeat (10) @(negedge clk);
      chk("rstmid_no_entry", irq_cnt - mark, 32'h0);
      chk("rstmid_in_isr", {31'b0, in_isr}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name:
interrupt_sequencer

Overview:
- Produces the `interrupt` handshake consumed by the Decode stage.
- Latches the external interrupt request, then waits for a safe pipeline point (no branch flush, no hazard stall, no CALL in Decode).
- Sequences interrupt entry as a multi-cycle operation: freeze front end, push return PC, push flags, read vector, load PC.
- Tracks ISR residency until RETI retires. Sits between Fetch, Decode and the data-memory/stack port.

Parameters:
- W, 16, data/address width
- FLAGS_W, 4, condition-code width
- VEC_ADDR, 16'h0000, memory address holding the ISR start address

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- int_req  in  1  external interrupt request; the rising edge is the event
- branch_signal  in  1  branch flush in progress
- detection_signal  in  1  hazard stall in progress
- call_in_decode  in  1  Decode holds CALL/RET/RETI
- pc_next  in  W  address of next unexecuted instruction
- flags_in  in  FLAGS_W  current CCR
- reti_done  in  1  RETI retired (1-cycle pulse)
- push_ready  in  1  stack port accepted push
- vec_rd_ready  in  1  vector read data valid
- vec_rd_data  in  W  vector read data
- interrupt  out  1  1-cycle pulse to Decode at entry
- stall  out  1  freeze PC and F/D buffer
- push_valid  out  1  stack push request
- push_data  out  W  stack push data
- vec_rd_valid  out  1  vector read request
- vec_addr  out  W  equals VEC_ADDR
- pc_load  out  1  load PC
- pc_load_value  out  W  ISR address
- in_isr  out  1  inside ISR

Behaviour:
- All outputs registered or decoded from registered state.
- Reset (rst=0, async): state=IDLE; pending, in_isr, saved_pc, saved_flags, vector and int_req history cleared; every output 0 except vec_addr=VEC_ADDR.
- Edge detect: req_edge = int_req & ~int_req_q, with int_req_q a registered copy of int_req.
- pending is set on req_edge in any state. It is cleared on the PENDING->PUSH_PC transition. Set has priority over clear in the same cycle.
- States: IDLE, PENDING, PUSH_PC, PUSH_FLAGS, VEC_RD, JUMP, ISR.
- IDLE: go to PENDING if (req_edge | pending).
- PENDING: safe = ~branch_signal & ~detection_signal & ~call_in_decode.
  - If safe: capture saved_pc<=pc_next and saved_flags<=flags_in, clear pending, go to PUSH_PC.
  - Otherwise remain in PENDING indefinitely.
- PUSH_PC:
  - push_valid=1, push_data=saved_pc.
  - interrupt=1 only in the first cycle of this state.
  - Go to PUSH_FLAGS on push_ready; otherwise hold with push_data stable.
- PUSH_FLAGS: push_valid=1, push_data={zeros, saved_flags}. Go to VEC_RD on push_ready.
- VEC_RD: vec_rd_valid=1. On vec_rd_ready, capture vector<=vec_rd_data and go to JUMP.
- JUMP: pc_load=1 and pc_load_value=vector for exactly one cycle; set in_isr<=1; go to ISR.
- ISR: in_isr=1. On reti_done, clear in_isr and go to IDLE. If pending is set, IDLE moves to PENDING on the next cycle (no nesting).
- stall=1 exactly in PUSH_PC, PUSH_FLAGS, VEC_RD and JUMP.
- reti_done outside ISR is ignored.
- A request edge during entry or ISR is remembered once; multiple edges collapse into one pending event.
- int_req held high generates a single event.
- Reset asserted mid-sequence aborts immediately with no partial push retry.

Test Plan:
- Basic entry (ready signals tied 1, pc_next=16'h0042, flags_in=4'b1010), int_req edge sampled at edge k:
  - PENDING after k; interrupt high cycle k+1; push 16'h0042 then 16'h000A.
  - With vec_rd_data=16'h0100: pc_load=1, pc_load_value=16'h0100 in cycle k+4; stall high cycles k+1..k+4; in_isr=1 from k+5.
- Deferral: detection_signal=1 for 3 cycles, then call_in_decode=1 for 2 cycles, during PENDING -> no push until both low; captured pc is the pc_next present on the release cycle.
- Backpressure: push_ready=0 for 4 cycles in PUSH_PC -> push_valid and push_data=saved_pc held; interrupt pulses once; sequence resumes afterwards.
- No nesting: second int_req edge while in ISR -> ignored until reti_done; then IDLE->PENDING->full entry again. Three edges in ISR -> one entry only.
- Reset mid-sequence: rst low during VEC_RD -> all outputs 0 immediately; pending=0; after release, no entry without a new edge.
- Stray reti_done in IDLE -> no state change; in_isr stays 0.
